// File: rtl/sine_seq_pkg.sv
// sine_seq_pkg: shared state type and sizing constants for the sine sequencer
package sine_seq_pkg;
  localparam int LUT_DEPTH = 32;
  localparam int ADDR_W = $clog2(LUT_DEPTH);
  localparam int SAMPLE_W = 8;
  localparam int PHASE_W_DEF = 8;
  localparam int CNT_W_DEF = 16;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
endpackage

// File: rtl/sine_out_reg.sv
// sine_out_reg: one-entry valid/ready output register for sequencer samples
// Ports: clk, rst (sync, active-high); load captures din and sets valid;
// clear drops valid; ready consumes the held sample; valid/data drive the stream.
module sine_out_reg
  import sine_seq_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic                clear,
  input  logic                ready,
  input  logic [SAMPLE_W-1:0] din,
  output logic                valid,
  output logic [SAMPLE_W-1:0] data
);
  always_ff @(posedge clk)
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else begin
      valid <= load | (valid & ~ready & ~clear);
      if (load) data <= din;
    end
endmodule

// File: rtl/sine_seq_ctrl.sv
// sine_seq_ctrl: phase-accumulator sequencer driving an external 32x8 sine table
// Ports: clk, rst (sync, active-high); cfg_phase/cfg_step/cfg_burst latched on start;
// start/stop pulses; busy/done status; lut_addr/lut_data table link; m_valid/m_ready/m_data stream.
// Build option: define SINE_SEQ_BURST_EN to honour cfg_burst; otherwise runs last until stop.
module sine_seq_ctrl
  import sine_seq_pkg::*;
#(
  parameter int PHASE_W = PHASE_W_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PHASE_W-1:0]  cfg_phase,
  input  logic [PHASE_W-1:0]  cfg_step,
  input  logic [CNT_W-1:0]    cfg_burst,
  input  logic                start,
  input  logic                stop,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W-1:0]   lut_addr,
  input  logic [SAMPLE_W-1:0] lut_data,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [SAMPLE_W-1:0] m_data
);
  state_t state, state_n;
  logic [PHASE_W-1:0] phase, step;
  logic load, clear, last;
  assign busy     = state != IDLE;
  assign lut_addr = phase[PHASE_W-1 -: ADDR_W];
  assign load     = (state == RUN) & ~stop & (~m_valid | m_ready);
  assign clear    = (state == DRAIN) & (~m_valid | m_ready);
`ifdef SINE_SEQ_BURST_EN
  logic [CNT_W-1:0] remaining;
  logic finite;
  // finite remembers a non-zero burst so a wrapped continuous counter never ends the run
  assign last = finite & (remaining == CNT_W'(1));
  always_ff @(posedge clk)
    if (rst) begin
      remaining <= '0;
      finite    <= 1'b0;
    end else if (state == IDLE && start) begin
      remaining <= cfg_burst;
      finite    <= |cfg_burst;
    end else if (load) remaining <= remaining - CNT_W'(1);
`else
  logic unused_burst;
  assign unused_burst = ^cfg_burst;
  assign last = 1'b0;
`endif
  always_comb begin
    state_n = state;
    state_n = state == IDLE ? (start ? RUN : IDLE)
            : state == RUN  ? ((stop | (load & last)) ? DRAIN : RUN)
            : (clear ? IDLE : DRAIN);
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      phase <= '0;
      step  <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      done  <= clear;
      if (state == IDLE && start) begin
        phase <= cfg_phase;
        step  <= cfg_step;
      end else if (load) phase <= phase + step;
    end
  sine_out_reg u_out (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .clear(clear),
    .ready(m_ready),
    .din  (lut_data),
    .valid(m_valid),
    .data (m_data)
  );
endmodule

// File: tb/tb_sine_seq_ctrl.sv
// tb_sine_seq_ctrl: vector table plus randomized runs against a sample-sequence model
module tb_sine_seq_ctrl;
  import sine_seq_pkg::*;
`ifdef SINE_SEQ_BURST_EN
  localparam bit BURST_EN = 1'b1;
`else
  localparam bit BURST_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst, start, stop, m_ready, busy, done, m_valid;
  logic [7:0] cfg_phase, cfg_step, lut_data, m_data;
  logic [15:0] cfg_burst;
  logic [4:0] lut_addr;
  logic [7:0] sine_tab [32];
  int vectors = 0, miscompares = 0;
  always #5 clk = ~clk;
  assign lut_data = sine_tab[lut_addr];
  sine_seq_ctrl dut (
    .clk(clk), .rst(rst), .cfg_phase(cfg_phase), .cfg_step(cfg_step), .cfg_burst(cfg_burst),
    .start(start), .stop(stop), .busy(busy), .done(done), .lut_addr(lut_addr),
    .lut_data(lut_data), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data)
  );
  typedef struct {
    logic [7:0]  phase, step;
    logic [15:0] burst;
    int          stop_after, mode;
    logic [7:0]  first0, first1;
  } vec_t;
  vec_t vecs [12];
  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  function automatic logic [7:0] ph(input logic [7:0] p0, input logic [7:0] st, input int i);
    return p0 + 8'(i * int'(st));
  endfunction
  function automatic logic [7:0] model(input logic [7:0] p0, input logic [7:0] st, input int i);
    logic [7:0] p;
    p = ph(p0, st, i);
    return sine_tab[p[7:3]];
  endfunction
  task automatic run_vec(input vec_t v, input int id);
    int eb, total, n, hf, lowcnt, stop_state;
    bit prev_hold, done_seen, burst_end;
    logic [7:0] pd, pa;
    eb = BURST_EN ? int'(v.burst) : 0;
    total = (eb == 0) ? v.stop_after + 1 : ((v.stop_after + 1 < eb) ? v.stop_after + 1 : eb);
    burst_end = (eb != 0) && (total == eb);
    @(negedge clk);
    cfg_phase = v.phase; cfg_step = v.step; cfg_burst = v.burst;
    start = 1'b1; stop = 1'b0; m_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0; hf = -1; lowcnt = 0; stop_state = 0; prev_hold = 1'b0; done_seen = 1'b0; pd = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (v.mode == 0 && cyc < 4 && cyc < total) begin
        pa = ph(v.phase, v.step, cyc);
        chk($sformatf("v%0d lut_addr%0d", id, cyc), lut_addr, pa[7:3]);
      end
      if (cyc == 1) chk($sformatf("v%0d latency", id), m_valid, 1);
      if (prev_hold) begin
        chk($sformatf("v%0d hold_valid", id), m_valid, 1);
        chk($sformatf("v%0d hold_data", id), m_data, pd);
      end
      if (done) begin
        done_seen = 1'b1;
        chk($sformatf("v%0d done_busy", id), busy, 0);
        chk($sformatf("v%0d done_valid", id), m_valid, 0);
        chk($sformatf("v%0d count", id), n, total);
        chk($sformatf("v%0d done_delay", id),
            int'(hf >= 0 && (burst_end ? cyc - hf == 1 : (cyc - hf >= 1 && cyc - hf <= 2))), 1);
        break;
      end
      m_ready = (v.mode == 0) ? 1'b1 : (v.mode == 2) ? (lowcnt == 0) : ($urandom_range(0, 3) != 0);
      if (lowcnt > 0) lowcnt--;
      stop = (stop_state == 1);
      if (stop_state == 1) stop_state = 2;
      if (cyc == 1) begin
        start = 1'b1; cfg_step = ~v.step; cfg_phase = v.phase + 8'h55; cfg_burst = v.burst + 16'd1;
      end else start = 1'b0;
      if (m_valid && m_ready) begin
        if (n < total) chk($sformatf("v%0d data%0d", id, n), m_data, model(v.phase, v.step, n));
        else chk($sformatf("v%0d extra_handshake", id), n, total - 1);
        if (n == 0) chk($sformatf("v%0d first0", id), m_data, v.first0);
        if (n == 1) chk($sformatf("v%0d first1", id), m_data, v.first1);
        n++;
        hf = cyc;
        if (v.mode == 2 && n == 2) lowcnt = 3;
        if (v.stop_after > 0 && n == v.stop_after && stop_state == 0) stop_state = 1;
      end
      prev_hold = m_valid && !m_ready;
      pd = m_data;
    end
    if (!done_seen) chk($sformatf("v%0d timeout", id), 0, 1);
    start = 1'b0; stop = 1'b0;
    @(negedge clk);
    chk($sformatf("v%0d done_len", id), done, 0);
  endtask
  initial begin
    sine_tab = '{100, 119, 138, 155, 170, 183, 192, 198, 200, 198, 192, 183, 170, 155, 138, 119,
                 100, 80, 61, 44, 29, 16, 7, 1, 0, 1, 7, 16, 29, 44, 61, 80};
    vecs[0] = '{8'h00, 8'h08, 16'd4, 6, 0, 8'd100, 8'd119};
    vecs[1] = '{8'h00, 8'h08, 16'd4, 6, 2, 8'd100, 8'd119};
    vecs[2] = '{8'h40, 8'h80, 16'd0, 6, 0, 8'd200, 8'd0};
    vecs[3] = '{8'hF8, 8'h10, 16'd3, 5, 1, 8'd80, 8'd119};
    vecs[4] = '{8'h10, 8'h00, 16'd5, 2, 1, 8'd138, 8'd138};
    vecs[5] = '{8'h40, 8'h08, 16'd2, 4, 1, 8'd200, 8'd198};
    for (int i = 6; i < 12; i++) begin
      vecs[i].phase = 8'($urandom);
      vecs[i].step = 8'($urandom);
      vecs[i].burst = 16'($urandom_range(0, 6));
      vecs[i].stop_after = $urandom_range(1, 8);
      vecs[i].mode = 1;
      vecs[i].first0 = model(vecs[i].phase, vecs[i].step, 0);
      vecs[i].first1 = model(vecs[i].phase, vecs[i].step, 1);
    end
    rst = 1'b1; start = 1'b0; stop = 1'b0; m_ready = 1'b0;
    cfg_phase = '0; cfg_step = '0; cfg_burst = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst m_valid", m_valid, 0);
    chk("rst m_data", m_data, 0);
    chk("rst lut_addr", lut_addr, 0);
    @(negedge clk);
    chk("idle busy", busy, 0);
    for (int i = 0; i < 12; i++) run_vec(vecs[i], i);
    cfg_phase = 8'h00; cfg_step = 8'h08; cfg_burst = 16'd0;
    start = 1'b1; stop = 1'b1; m_ready = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    chk("start_wins busy", busy, 1);
    repeat (3) @(negedge clk);
    chk("pre_rst valid", m_valid, 1);
    chk("pre_rst data", m_data, 138);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst valid", m_valid, 0);
    chk("mid_rst busy", busy, 0);
    chk("mid_rst done", done, 0);
    chk("mid_rst lut_addr", lut_addr, 0);
    chk("mid_rst data", m_data, 0);
    @(negedge clk);
    chk("post_rst done", done, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/sine_seq_ctrl.md
# sine_seq_ctrl

Sequencer for the 32-entry, 8-bit sine lookup datapath. It owns a phase accumulator and drives the table address. It registers the returned sample into a valid/ready output stage. Software-style configuration (start phase, phase step, burst length) turns the fixed-rate table scan into a programmable-frequency, start/stop-controlled sample source for downstream consumers.

## Interface
Parameters:
- PHASE_W, 8, phase accumulator width; table address is phase[PHASE_W-1 -: 5]
- CNT_W, 16, burst counter width

Ports:
- clk  in  1  rising-edge clock, single clock domain
- rst  in  1  synchronous, active-high reset
- cfg_phase  in  PHASE_W  start phase, latched on accepted start
- cfg_step  in  PHASE_W  phase increment per emitted sample, latched on accepted start
- cfg_burst  in  CNT_W  samples per burst; 0 = continuous; latched on accepted start
- start  in  1  single-cycle request; honoured only in IDLE
- stop  in  1  single-cycle request; honoured only in RUN
- busy  out  1  high when state != IDLE
- done  out  1  one-cycle pulse on return to IDLE
- lut_addr  out  5  table address = phase[PHASE_W-1:PHASE_W-5], combinational from phase register
- lut_data  in  8  table sample for lut_addr, combinational, same cycle
- m_valid  out  1  output sample valid
- m_ready  in  1  consumer ready
- m_data  out  8  output sample

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE:
  - On start: phase<=cfg_phase, step<=cfg_step, remaining<=cfg_burst, go to RUN.
  - stop is ignored in IDLE.
  - start and stop in the same cycle: start wins.
- RUN:
  - load = ~m_valid | m_ready.
  - On load with no stop: m_data<=lut_data, m_valid<=1, phase<=phase+step (mod 2^PHASE_W), remaining<=remaining-1.
  - If burst is non-zero and remaining==1 at load, go to DRAIN.
  - stop in RUN suppresses that cycle's load and goes to DRAIN. A held sample is not discarded.
- DRAIN:
  - No loads.
  - When m_valid==0, or on handshake m_valid&m_ready: clear m_valid, go to IDLE, pulse done.
- start while busy is ignored and never re-latches configuration.
- Phase wraps silently, e.g. 0xF8+0x10 -> 0x08.
- step=0 is legal and repeats one sample.
- Reset values:
  - busy=0, done=0, m_valid=0, m_data=0
  - phase=0 (lut_addr=0), remaining=0, state=IDLE
- rst mid-operation abandons the burst with no done pulse. m_valid is 0 in the cycle after the reset edge.

## Timing
- Start accepted at edge t. First load at edge t+1. m_valid is visible after edge t+1, i.e. 2 cycles start-to-valid.
- Throughput is 1 sample/cycle with m_ready held high.
- m_data/m_valid are stable while m_valid & ~m_ready (AXI-stream rule).
- done asserts the cycle after the final handshake edge and lasts exactly 1 cycle. busy falls in the same cycle as done.
- No combinational path from m_ready to m_valid or m_data.
- m_ready affects lut_addr only via the phase register, one cycle later.

## Configuration
- SINE_SEQ_BURST_EN defined:
  - cfg_burst is honoured; non-zero values end RUN after exactly cfg_burst samples.
  - 0 means continuous.
- SINE_SEQ_BURST_EN undefined:
  - Burst counter logic is removed and cfg_burst is ignored (port kept).
  - Every run is continuous until stop.

## Structure
- Package sine_seq_pkg holds:
  - state enum (IDLE/RUN/DRAIN)
  - ADDR_W=5, LUT_DEPTH=32, SAMPLE_W=8
  - default PHASE_W/CNT_W constants
- Sub-module sine_out_reg: one-entry valid/ready output register with load/clear inputs, holding m_data/m_valid.
- The FSM, accumulator and burst counter stay in sine_seq_ctrl.
- The table itself is external, connected through lut_addr/lut_data.

## Test plan
1. Reset: assert rst 2 cycles, then release -> busy=0, done=0, m_valid=0, m_data=0, lut_addr=0.
2. cfg_phase=0, cfg_step=8, cfg_burst=4, m_ready=1, start pulse:
   - lut_addr goes 0,1,2,3.
   - m_data goes 100,119,138,155 on consecutive cycles starting 2 cycles after start.
   - done pulses once, one cycle after the 4th handshake.
3. Same config, m_ready low for 3 cycles after the 2nd sample -> m_data holds 119 unchanged, then 138,155 follow with no skip or duplicate; exactly 4 handshakes.
4. cfg_phase=0x40, cfg_step=0x80, cfg_burst=0:
   - m_data alternates 200,0,200,0.
   - stop after 6 handshakes -> DRAIN, held sample delivered, done pulse, busy=0.
5. start pulsed during RUN with different cfg_step -> stream unchanged. rst asserted mid-burst -> m_valid=0 next cycle, no done.
6. Build without SINE_SEQ_BURST_EN, cfg_burst=4 -> more than 4 samples emitted, run ends only on stop.
